// File: rtl/multi_row_reorder_crossbar_if.sv
// Batch-in / row-out bus of the multi-row reorder crossbar.
// Valid/ready: a transfer happens on a clk edge where valid and ready are both 1;
// the source keeps valid and its data stable until that edge, and ready never
// depends on valid from the same side.
interface multi_row_reorder_crossbar_if #(
    parameter int NUM_IN    = 8,
    parameter int NUM_OUT   = 4,
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 40
);
    // batch side (hash PE scheduler -> crossbar)
    logic                          input_valid;
    logic [NUM_IN-1:0]             input_mask;
    logic [NUM_IN*ADDR_W-1:0]      input_addr;
    logic [NUM_IN*PAYLOAD_W-1:0]   input_payload;
    logic [NUM_IN-1:0]             input_delim;
    logic                          input_ready;
    // row side (crossbar -> match-row consumer)
    logic                          output_valid;
    logic [ADDR_W-1:0]             output_head_addr;
    logic [NUM_OUT-1:0]            output_row_valid;
    logic [NUM_OUT*PAYLOAD_W-1:0]  output_payload;
    logic                          output_last;
    logic                          output_delim;
    logic                          output_ready;

    // environment: produces batches, consumes rows
    modport master (
        output input_valid, input_mask, input_addr, input_payload, input_delim,
        input  input_ready,
        input  output_valid, output_head_addr, output_row_valid, output_payload,
        input  output_last, output_delim,
        output output_ready
    );

    // crossbar: consumes batches, produces rows
    modport slave (
        input  input_valid, input_mask, input_addr, input_payload, input_delim,
        output input_ready,
        output output_valid, output_head_addr, output_row_valid, output_payload,
        output output_last, output_delim,
        input  output_ready
    );
endinterface

// File: rtl/multi_row_reorder_crossbar.sv
// Scatters a batch of PE results into NUM_OUT-wide rows keyed by the low
// address bits. Entries that fall in another row or collide on a slot stay
// pending and drain on later beats, one output row per beat.
module multi_row_reorder_crossbar #(
    parameter int NUM_IN    = 8,
    parameter int NUM_OUT   = 4,
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 40,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    multi_row_reorder_crossbar_if.slave   io,
    output logic [CNT_W-1:0]              collision_cnt
);
    localparam int SEL_W = $clog2(NUM_OUT);
    localparam int DEF_W = $clog2(NUM_IN + 1);
    localparam int SUM_W = CNT_W + 1;

    // pending batch; batch_active also covers an all-zero mask batch that
    // still owes its single empty beat
    logic                               batch_active;
    logic [NUM_IN-1:0]                  pend_mask;
    logic [NUM_IN-1:0][ADDR_W-1:0]      pend_addr;
    logic [NUM_IN-1:0][PAYLOAD_W-1:0]   pend_payload;
    logic                               pend_delim;

    // beat formed from the pending set
    logic                               lead_found;
    logic [ADDR_W-1:0]                  beat_row;
    logic [NUM_IN-1:0]                  cand;
    logic [NUM_IN-1:0]                  winners;
    logic [NUM_OUT-1:0]                 beat_row_valid;
    logic [NUM_OUT-1:0][PAYLOAD_W-1:0]  beat_payload;
    logic                               beat_last;
    logic [DEF_W-1:0]                   beat_deferred;

    // one-deep output register
    logic                               out_valid;
    logic [ADDR_W-1:0]                  out_head;
    logic [NUM_OUT-1:0]                 out_row_valid;
    logic [NUM_OUT-1:0][PAYLOAD_W-1:0]  out_payload;
    logic                               out_last;
    logic                               out_delim;

    logic                               load;
    logic                               final_load;
    logic                               fire;
    logic [SUM_W-1:0]                   cnt_sum;

    // pick the lead row, then the lowest-index candidate per slot
    always_comb begin
        lead_found     = 1'b0;
        beat_row       = '0;
        cand           = '0;
        winners        = '0;
        beat_row_valid = '0;
        beat_payload   = '0;
        beat_deferred  = '0;
        beat_last      = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pend_mask[i] && !lead_found) begin
                lead_found = 1'b1;
                beat_row   = {pend_addr[i][ADDR_W-1:SEL_W], {SEL_W{1'b0}}};
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            cand[i] = pend_mask[i] &&
                      (pend_addr[i][ADDR_W-1:SEL_W] == beat_row[ADDR_W-1:SEL_W]);
        end
        for (int s = 0; s < NUM_OUT; s++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (cand[i] && !beat_row_valid[s] &&
                    (pend_addr[i][SEL_W-1:0] == SEL_W'(s))) begin
                    beat_row_valid[s] = 1'b1;
                    winners[i]        = 1'b1;
                    beat_payload[s]   = pend_payload[i];
                end
            end
        end
        // a candidate that did not win lost its slot to a lower-index entry
        for (int i = 0; i < NUM_IN; i++) begin
            if (cand[i] && !winners[i]) begin
                beat_deferred = beat_deferred + DEF_W'(1);
            end
        end
        beat_last = ((pend_mask & ~winners) == '0);
    end

    assign load           = batch_active && (!out_valid || io.output_ready);
    assign final_load     = load && beat_last;
    assign io.input_ready = !rst && (!batch_active || final_load);
    assign fire           = io.input_valid && io.input_ready;
    assign cnt_sum        = {1'b0, collision_cnt} + SUM_W'(beat_deferred);

    // pending set: drop winners on load; a new batch overwrites it on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            batch_active <= 1'b0;
            pend_mask    <= '0;
            pend_addr    <= '0;
            pend_payload <= '0;
            pend_delim   <= 1'b0;
        end else begin
            if (load) begin
                pend_mask <= pend_mask & ~winners;
                if (beat_last) begin
                    batch_active <= 1'b0;
                end
            end
            if (fire) begin
                batch_active <= 1'b1;
                pend_mask    <= io.input_mask;
                pend_addr    <= io.input_addr;
                pend_payload <= io.input_payload;
                pend_delim   <= |(io.input_mask & io.input_delim);
            end
        end
    end

    // output register: capture a beat when empty or being accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_head      <= '0;
            out_row_valid <= '0;
            out_payload   <= '0;
            out_last      <= 1'b0;
            out_delim     <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_head      <= beat_row;
            out_row_valid <= beat_row_valid;
            out_payload   <= beat_payload;
            out_last      <= beat_last;
            out_delim     <= beat_last & pend_delim;
        end else if (io.output_ready) begin
            out_valid <= 1'b0;
        end
    end

    // saturating count of entries deferred by slot collisions
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_cnt <= '0;
        end else if (load) begin
            if (cnt_sum[CNT_W]) begin
                collision_cnt <= '1;
            end else begin
                collision_cnt <= cnt_sum[CNT_W-1:0];
            end
        end
    end

    assign io.output_valid     = out_valid;
    assign io.output_head_addr = out_head;
    assign io.output_row_valid = out_row_valid;
    assign io.output_payload   = out_payload;
    assign io.output_last      = out_last;
    assign io.output_delim     = out_delim;
endmodule

// File: tb/tb_multi_row_reorder_crossbar.sv
// Bench for multi_row_reorder_crossbar: directed scenarios plus random batches,
// every accepted row checked against a queue filled by a per-batch reference model.
module tb_multi_row_reorder_crossbar;
    localparam int NUM_IN    = 4;
    localparam int NUM_OUT   = 4;
    localparam int ADDR_W    = 8;
    localparam int PAYLOAD_W = 40;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0]            head;
        logic [NUM_OUT-1:0]           row_valid;
        logic [NUM_OUT*PAYLOAD_W-1:0] payload;
        logic                         last;
        logic                         delim;
        logic [CNT_W-1:0]             cnt;
    } beat_t;
    localparam int BEAT_W = $bits(beat_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] collision_cnt;
    logic rand_ready = 1'b0;

    logic [BEAT_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  exp_cnt = '0;
    int n_checks = 0;
    int n_errors = 0;
    int entries_out = 0;
    int exp_entries = 0;
    beat_t mon_e;

    multi_row_reorder_crossbar_if #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W)
    ) bus ();

    multi_row_reorder_crossbar #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W),
        .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus),
        .collision_cnt(collision_cnt)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: peel rows off the batch one beat at a time
    task automatic model_batch(input logic [NUM_IN-1:0] mask,
                               input logic [NUM_IN*ADDR_W-1:0] addrs,
                               input logic [NUM_IN*PAYLOAD_W-1:0] pls,
                               input logic [NUM_IN-1:0] delim);
        int rem[$];
        int keep[$];
        beat_t b;
        int deferred;
        int row_base;
        int a;
        int slot;
        logic any_delim;
        any_delim = |(mask & delim);
        for (int i = 0; i < NUM_IN; i++) if (mask[i]) rem.push_back(i);
        exp_entries += $countones(mask);
        do begin
            b = '0;
            deferred = 0;
            keep.delete();
            if (rem.size() > 0) begin
                row_base = (int'(addrs[rem[0]*ADDR_W +: ADDR_W]) / NUM_OUT) * NUM_OUT;
                b.head = ADDR_W'(row_base);
                foreach (rem[k]) begin
                    a = int'(addrs[rem[k]*ADDR_W +: ADDR_W]);
                    slot = a % NUM_OUT;
                    if ((a / NUM_OUT) * NUM_OUT != row_base) begin
                        keep.push_back(rem[k]);
                    end else if (!b.row_valid[slot]) begin
                        b.row_valid[slot] = 1'b1;
                        b.payload[slot*PAYLOAD_W +: PAYLOAD_W] = pls[rem[k]*PAYLOAD_W +: PAYLOAD_W];
                    end else begin
                        deferred++;
                        keep.push_back(rem[k]);
                    end
                end
                rem = keep;
            end
            b.last  = (rem.size() == 0);
            b.delim = b.last & any_delim;
            if (int'(exp_cnt) + deferred > CNT_MAX) exp_cnt = '1;
            else exp_cnt = exp_cnt + CNT_W'(deferred);
            b.cnt = exp_cnt;
            exp_q.push_back(b);
        end while (rem.size() > 0);
    endtask

    // driver: advance one cycle, optionally jitter output_ready
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.output_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_batch(input logic [NUM_IN-1:0] mask,
                              input logic [NUM_IN*ADDR_W-1:0] addrs,
                              input logic [NUM_IN*PAYLOAD_W-1:0] pls,
                              input logic [NUM_IN-1:0] delim);
        bit fired = 0;
        bus.input_valid   = 1'b1;
        bus.input_mask    = mask;
        bus.input_addr    = addrs;
        bus.input_payload = pls;
        bus.input_delim   = delim;
        for (int c = 0; c < 200 && !fired; c++) begin
            @(negedge clk);
            if (bus.input_ready) fired = 1;
            tick();
        end
        bus.input_valid = 1'b0;
        if (fired) model_batch(mask, addrs, pls, delim);
        else check("input_ready_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || bus.output_valid) && c < 300) begin
            tick();
            c++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // scoreboard: every accepted row against the model's next beat
    always @(negedge clk) begin
        if (!rst && bus.output_valid && bus.output_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("head", bus.output_head_addr, mon_e.head);
                check("row_valid", bus.output_row_valid, mon_e.row_valid);
                check("payload", bus.output_payload, mon_e.payload);
                check("last", bus.output_last, mon_e.last);
                check("delim", bus.output_delim, mon_e.delim);
                check("collision_cnt", collision_cnt, mon_e.cnt);
                entries_out += $countones(bus.output_row_valid);
            end
        end
    end

    localparam logic [NUM_IN*ADDR_W-1:0]    S1_ADDR = {8'h13, 8'h12, 8'h11, 8'h10};
    localparam logic [NUM_IN*PAYLOAD_W-1:0] S1_PL   = {40'hDD_0000_00DD, 40'hCC_0000_00CC,
                                                       40'hBB_0000_00BB, 40'hAA_0000_00AA};
    localparam logic [NUM_IN*ADDR_W-1:0]    S2_ADDR = {8'h00, 8'h00, 8'h12, 8'h12};
    localparam logic [NUM_IN*PAYLOAD_W-1:0] S2_PL   = {40'h0, 40'h0, 40'h22_2222_2222, 40'h11_1111_1111};
    localparam logic [NUM_IN*ADDR_W-1:0]    S3_ADDR = {8'h00, 8'h00, 8'h11, 8'h24};

    initial begin
        logic [CNT_W-1:0] cnt_before;
        int ent_before;
        logic [NUM_IN-1:0] r_mask;
        logic [NUM_IN*ADDR_W-1:0] r_addr;
        logic [NUM_IN*PAYLOAD_W-1:0] r_pl;
        logic [NUM_IN-1:0] r_delim;

        bus.input_valid   = 1'b0;
        bus.input_mask    = '0;
        bus.input_addr    = '0;
        bus.input_payload = '0;
        bus.input_delim   = '0;
        bus.output_ready  = 1'b1;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_output_valid", bus.output_valid, 0);
        check("rst_input_ready", bus.input_ready, 0);
        check("rst_collision_cnt", collision_cnt, 0);
        check("rst_head", bus.output_head_addr, 0);
        check("rst_row_valid", bus.output_row_valid, 0);
        check("rst_payload", bus.output_payload, 0);
        check("rst_last_delim", {bus.output_last, bus.output_delim}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_input_ready", bus.input_ready, 1);
        tick();

        // full row, no collisions; single final beat lets a new batch in at once
        send_batch(4'b1111, S1_ADDR, S1_PL, 4'b0000);
        @(negedge clk);
        check("s1_latency_valid", bus.output_valid, 0);
        check("s1_input_ready", bus.input_ready, 1);
        wait_drain();

        // two PEs on the same slot: two beats, one deferral
        cnt_before = exp_cnt;
        send_batch(4'b0011, S2_ADDR, S2_PL, 4'b0000);
        wait_drain();
        check("s2_cnt_step", collision_cnt, cnt_before + CNT_W'(1));

        // two rows, delimiter reported only on the last beat
        send_batch(4'b0011, S3_ADDR, S2_PL, 4'b0010);
        wait_drain();

        // empty mask still yields one empty final beat
        send_batch(4'b0000, S1_ADDR, S1_PL, 4'b1111);
        wait_drain();

        // collision batch under 5 cycles of backpressure
        ent_before = entries_out;
        bus.output_ready = 1'b0;
        send_batch(4'b0011, S2_ADDR, S2_PL, 4'b0000);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mon_e = exp_q[0];
            check("hold_valid", bus.output_valid, 1);
            check("hold_row", {bus.output_head_addr, bus.output_row_valid, bus.output_last},
                  {mon_e.head, mon_e.row_valid, mon_e.last});
            check("hold_payload", bus.output_payload, mon_e.payload);
            check("hold_input_ready", bus.input_ready, 0);
            tick();
        end
        bus.output_ready = 1'b1;
        wait_drain();
        check("hold_entries_out", entries_out - ent_before, 2);

        // reset while the first beat of a collision batch is held
        bus.output_ready = 1'b0;
        send_batch(4'b0011, S2_ADDR, S2_PL, 4'b0000);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_input_ready", bus.input_ready, 0);
        tick();
        rst = 1'b0;
        bus.output_ready = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        entries_out = 0;
        exp_entries = 0;
        @(negedge clk);
        check("postrst_output_valid", bus.output_valid, 0);
        check("postrst_collision_cnt", collision_cnt, 0);
        check("postrst_input_ready", bus.input_ready, 1);
        tick();
        send_batch(4'b1111, S1_ADDR, S1_PL, 4'b0000);
        wait_drain();

        // random batches over three rows with jittered output_ready
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            r_mask  = NUM_IN'($urandom_range(0, 15));
            r_delim = NUM_IN'($urandom_range(0, 15));
            for (int i = 0; i < NUM_IN; i++) begin
                r_addr[i*ADDR_W +: ADDR_W]     = ADDR_W'(8'h40 + $urandom_range(0, 11));
                r_pl[i*PAYLOAD_W +: PAYLOAD_W] = PAYLOAD_W'({$urandom(), $urandom()});
            end
            send_batch(r_mask, r_addr, r_pl, r_delim);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        rand_ready = 1'b0;
        bus.output_ready = 1'b1;
        wait_drain();
        check("rand_entries_out", entries_out, exp_entries);
        check("rand_collision_cnt", collision_cnt, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
